// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Arbitrates the memory wait,
// multi-cycle EX ops, redirects and load-use hazards, and counts PC stall cycles.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_is_mc,
  input  logic                  ex_redirect,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_ld,
  output logic                  ifid_ld,
  output logic                  idex_ld,
  output logic                  exmem_ld,
  output logic                  memwb_ld,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  mc_done,
  output logic [PERF_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {RUN, MC_BUSY, MC_DONE} state_t;

  // The entry cycle and the done cycle both occupy EX, so the busy phase lasts MC_LATENCY-2.
  localparam logic [3:0] MC_LOAD = 4'(MC_LATENCY - 1);

  state_t     state;
  logic [3:0] mc_cnt;
  logic       memstall, load_use, mc_start;

  always_comb begin
    memstall = dmem_req & ~dmem_ready;
    load_use = ex_is_load && (ex_rd != '0) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    mc_start = (state == RUN) && ex_is_mc;

    pc_ld       = 1'b0;
    ifid_ld     = 1'b0;
    idex_ld     = 1'b0;
    exmem_ld    = 1'b0;
    memwb_ld    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mc_done     = 1'b0;

    if (!reset) begin
      // held in reset: everything frozen
    end else if (memstall) begin
      mc_done = (state == MC_DONE);
    end else if ((state == MC_BUSY) || mc_start) begin
      exmem_ld    = 1'b1;
      exmem_flush = 1'b1;
      memwb_ld    = 1'b1;
    end else if (state == MC_DONE) begin
      {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld} = '1;
      mc_done = 1'b1;
    end else if (ex_redirect) begin
      // Redirect wins over load-use: the dependent instruction is squashed anyway.
      {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld} = '1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      idex_ld    = 1'b1;
      idex_flush = 1'b1;
      exmem_ld   = 1'b1;
      memwb_ld   = 1'b1;
    end else begin
      {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld} = '1;
    end
  end

  // The busy countdown ignores memstall; only MC_DONE waits for the memory to release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      case (state)
        RUN: if (!memstall && ex_is_mc) begin
          mc_cnt <= MC_LOAD;
          state  <= (MC_LOAD == 4'd1) ? MC_DONE : MC_BUSY;
        end
        MC_BUSY: begin
          mc_cnt <= mc_cnt - 4'd1;
          if (mc_cnt == 4'd2) state <= MC_DONE;
        end
        MC_DONE: if (!memstall) begin
          state  <= RUN;
          mc_cnt <= '0;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (!pc_ld && (stall_cnt != '1))
      stall_cnt <= stall_cnt + PERF_W'(1);
  end

endmodule
